mips32_multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS32 SOC datapath: replaces single-cycle decode with a Moore FSM.

---
 rtl/mips32_multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mips32_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mips32_multicycle_ctrl.sv
// Multi-cycle Moore sequencer for the shared MIPS32 datapath (FETCH/DECODE/EXEC/MEM/WB).
// Define MIPS32_MC_PERF_EN to build the live retired-instruction counter.
module mips32_multicycle_ctrl #(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opc,
    input  logic [5:0]  func,
    input  logic        aluZero,
    input  logic        memReady,
    output logic        pcWrite,
    output logic        irWrite,
    output logic        iOrD,
    output logic        memRead,
    output logic        memWrite,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [2:0]  aluFunc,
    output logic [1:0]  pcSrc,
    output logic        bitXtend,
    output logic        rfWriteEnable,
    output logic        rfWriteAddrSel,
    output logic [1:0]  rfWriteDataSel,
    output logic        invOpcode,
    output logic        memFault,
    output logic [31:0] instRetired
);
    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_RWB, S_MEMADDR, S_MEMRD,
        S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_INVALID, S_HALT
    } state_t;

    // fetch/branch mark the states whose pcWrite/irWrite also follow an input
    typedef struct packed {
        logic       pc_write;
        logic       fetch;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_func;
        logic [1:0] pc_src;
        logic       rf_we;
        logic       rf_wa_sel;
        logic [1:0] rf_wd_sel;
        logic       inv;
    } ctrl_t;

    function automatic logic r_func_ok(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    function automatic logic [2:0] r_alu_func(input logic [5:0] fn);
        case (fn)
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h2A:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch = 1'b1; c.mem_read = 1'b1;
                c.alu_src_b = 2'd1; c.alu_func = ALU_ADD;
            end
            S_DECODE:  begin c.alu_src_b = 2'd3; c.alu_func = ALU_ADD; end
            S_EXEC_R:  begin c.alu_src_a = 1'b1; c.alu_func = r_alu_func(fn); end
            S_RWB:     begin c.rf_we = 1'b1; c.rf_wa_sel = 1'b1; end
            S_MEMADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_func = ALU_ADD; end
            S_MEMRD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            S_MEMWB:   begin c.rf_we = 1'b1; c.rf_wd_sel = 2'd1; end
            S_MEMWR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            S_BRANCH: begin
                c.branch = 1'b1; c.alu_src_a = 1'b1;
                c.alu_func = ALU_SUB; c.pc_src = 2'd1;
            end
            S_JUMP:    begin c.pc_write = 1'b1; c.pc_src = 2'd2; end
            S_INVALID: c.inv = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_fault_q, mem_fault_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       mem_state;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        mem_fault_d = mem_fault_q;
        case (state_q)
            S_FETCH:  if (memReady) state_d = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OP_RTYPE:     state_d = r_func_ok(func) ? S_EXEC_R : S_INVALID;
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_INVALID;
                endcase
            end
            S_EXEC_R:  state_d = S_RWB;
            S_MEMADDR: state_d = (opc == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (memReady) state_d = S_MEMWB;
            S_MEMWR:   if (memReady) state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
        // a stalled memory state counts up; the last allowed wait trips the fault
        if (mem_state && !memReady) begin
            if (wait_q == WAIT_LAST) begin
                mem_fault_d = 1'b1;
                state_d     = S_HALT;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
        ctrl_d = decode_ctrl(state_d, func);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            mem_fault_q <= 1'b0;
            ctrl_q      <= decode_ctrl(S_FETCH, 6'h00);
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_fault_q <= mem_fault_d;
            ctrl_q      <= ctrl_d;
        end
    end

`ifdef MIPS32_MC_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic        retire;

    assign retire = (state_q == S_RWB) || (state_q == S_MEMWB) || (state_q == S_BRANCH) ||
                    (state_q == S_JUMP) || ((state_q == S_MEMWR) && memReady);
    assign retired_d = retired_q + 32'(retire);

    always_ff @(posedge clk) begin
        if (rst) retired_q <= '0;
        else     retired_q <= retired_d;
    end

    assign instRetired = rst ? 32'd0 : retired_q;
`else
    assign instRetired = 32'd0;
`endif

    logic br_take;
    assign br_take = (opc == OP_BEQ) ? aluZero : !aluZero;

    assign pcWrite        = !rst && (ctrl_q.pc_write || (ctrl_q.fetch && memReady) ||
                                     (ctrl_q.branch && br_take));
    assign irWrite        = !rst && ctrl_q.fetch && memReady;
    assign iOrD           = !rst && ctrl_q.i_or_d;
    assign memRead        = !rst && ctrl_q.mem_read;
    assign memWrite       = !rst && ctrl_q.mem_write;
    assign aluSrcA        = !rst && ctrl_q.alu_src_a;
    assign aluSrcB        = rst ? 2'd0 : ctrl_q.alu_src_b;
    assign aluFunc        = rst ? 3'd0 : ctrl_q.alu_func;
    assign pcSrc          = rst ? 2'd0 : ctrl_q.pc_src;
    assign bitXtend       = 1'b0;
    assign rfWriteEnable  = !rst && ctrl_q.rf_we;
    assign rfWriteAddrSel = !rst && ctrl_q.rf_wa_sel;
    assign rfWriteDataSel = rst ? 2'd0 : ctrl_q.rf_wd_sel;
    assign invOpcode      = !rst && ctrl_q.inv;
    assign memFault       = !rst && mem_fault_q;
endmodule

// File: tb/tb_mips32_multicycle_ctrl.sv
// Scoreboard bench: each instruction pushes its expected per-cycle control vectors,
// then the queue is drained one cycle at a time against the DUT.
module tb_mips32_multicycle_ctrl;
    localparam int TMO = 4;
`ifdef MIPS32_MC_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, aluZero, memReady;
    logic [5:0]  opc, func;
    logic        pcWrite, irWrite, iOrD, memRead, memWrite, aluSrcA, bitXtend;
    logic [1:0]  aluSrcB, pcSrc, rfWriteDataSel;
    logic [2:0]  aluFunc;
    logic        rfWriteEnable, rfWriteAddrSel, invOpcode, memFault;
    logic [31:0] instRetired;

    mips32_multicycle_ctrl #(.WAIT_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .opc(opc), .func(func), .aluZero(aluZero), .memReady(memReady),
        .pcWrite(pcWrite), .irWrite(irWrite), .iOrD(iOrD), .memRead(memRead),
        .memWrite(memWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluFunc(aluFunc),
        .pcSrc(pcSrc), .bitXtend(bitXtend), .rfWriteEnable(rfWriteEnable),
        .rfWriteAddrSel(rfWriteAddrSel), .rfWriteDataSel(rfWriteDataSel),
        .invOpcode(invOpcode), .memFault(memFault), .instRetired(instRetired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, irw, iord, mrd, mwr, srca;
        logic [1:0] srcb;
        logic [2:0] fn;
        logic [1:0] pcsrc;
        logic xt, rfwe, rfwa;
        logic [1:0] rfwd;
        logic inv, fault;
    } obs_t;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        obs_t       exp;
    } item_t;

    localparam int F = 0, D = 1, ER = 2, RWB = 3, MA = 4, MRD = 5, MWB = 6, MWR = 7,
                   BR = 8, JP = 9, INV = 10, HLT = 11;
    string snames [12] = '{"fetch", "decode", "exec_r", "rwb", "memaddr", "memrd",
                           "memwb", "memwr", "branch", "jump", "invalid", "halt"};

    obs_t  got;
    item_t q[$];
    int    n_chk = 0, n_fail = 0;
    int    exp_ret = 0;
    logic [2:0] cur_fn;
    logic       cur_beq, cur_z;

    assign got = {pcWrite, irWrite, iOrD, memRead, memWrite, aluSrcA, aluSrcB, aluFunc,
                  pcSrc, bitXtend, rfWriteEnable, rfWriteAddrSel, rfWriteDataSel,
                  invOpcode, memFault};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic obs_t model(input int st, input logic rdy);
        obs_t o;
        o = '0;
        case (st)
            F:   begin o.mrd = 1; o.srcb = 2'd1; o.fn = 3'd2; o.irw = rdy; o.pcw = rdy; end
            D:   begin o.srcb = 2'd3; o.fn = 3'd2; end
            ER:  begin o.srca = 1; o.fn = cur_fn; end
            RWB: begin o.rfwe = 1; o.rfwa = 1; end
            MA:  begin o.srca = 1; o.srcb = 2'd2; o.fn = 3'd2; end
            MRD: begin o.mrd = 1; o.iord = 1; end
            MWB: begin o.rfwe = 1; o.rfwd = 2'd1; end
            MWR: begin o.mwr = 1; o.iord = 1; end
            BR:  begin o.srca = 1; o.fn = 3'd6; o.pcsrc = 2'd1; o.pcw = cur_beq ? cur_z : !cur_z; end
            JP:  begin o.pcsrc = 2'd2; o.pcw = 1; end
            INV: o.inv = 1;
            HLT: o.fault = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic push(input int st, input logic rdy);
        item_t it;
        it.st  = 4'(st);
        it.rdy = rdy;
        it.exp = model(st, rdy);
        q.push_back(it);
    endtask

    // entered and left at posedge+1
    task automatic run_q();
        item_t it;
        while (q.size() > 0) begin
            it = q.pop_front();
            memReady = it.rdy;
            #1;
            chk(snames[it.st], 32'(got), 32'(it.exp));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        memReady = 1'b1;
        #1;
        chk("rst_outputs", 32'(got), 32'd0);
        chk("rst_retired", instRetired, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = 0;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fst, input int mst);
        bit retires;
        opc = op; func = fn; aluZero = z;
        cur_beq = (op == 6'h04);
        cur_z = z;
        case (fn)
            6'h20: cur_fn = 3'd2;
            6'h22: cur_fn = 3'd6;
            6'h24: cur_fn = 3'd0;
            6'h25: cur_fn = 3'd1;
            default: cur_fn = 3'd7;
        endcase
        retires = 1'b1;
        for (int i = 0; i < fst; i++) push(F, 1'b0);
        push(F, 1'b1);
        push(D, 1'b0);
        if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
            push(ER, 1'b0); push(RWB, 1'b0);
        end else if (op == 6'h23) begin
            push(MA, 1'b0);
            for (int i = 0; i < mst; i++) push(MRD, 1'b0);
            push(MRD, 1'b1); push(MWB, 1'b0);
        end else if (op == 6'h2B) begin
            push(MA, 1'b0);
            for (int i = 0; i < mst; i++) push(MWR, 1'b0);
            push(MWR, 1'b1);
        end else if (op == 6'h04 || op == 6'h05) begin
            push(BR, 1'b0);
        end else if (op == 6'h02) begin
            push(JP, 1'b0);
        end else begin
            push(INV, 1'b0);
            retires = 1'b0;
        end
        run_q();
        if (retires) exp_ret++;
        chk("retired", instRetired, PERF ? 32'(exp_ret) : 32'd0);
    endtask

    initial begin
        rst = 1'b1; memReady = 1'b0; opc = '0; func = '0; aluZero = 1'b0;
        cur_fn = '0; cur_beq = 1'b0; cur_z = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(got), 32'd0);
        chk("reset_retired", instRetired, 32'd0);
        rst = 1'b0;

        instr(6'h00, 6'h20, 1'b0, 0, 0);   // ADD
        instr(6'h23, 6'h00, 1'b0, 0, 3);   // LW, three stalled reads
        instr(6'h04, 6'h00, 1'b1, 0, 0);   // BEQ taken
        instr(6'h05, 6'h00, 1'b1, 0, 0);   // BNE not taken
        instr(6'h04, 6'h00, 1'b0, 0, 0);
        instr(6'h05, 6'h00, 1'b0, 0, 0);
        instr(6'h3F, 6'h00, 1'b0, 0, 0);   // unsupported opcode
        instr(6'h00, 6'h21, 1'b0, 0, 0);   // unsupported R func
        instr(6'h00, 6'h22, 1'b0, 0, 0);
        instr(6'h00, 6'h24, 1'b0, 0, 0);
        instr(6'h00, 6'h25, 1'b0, 0, 0);
        instr(6'h00, 6'h2A, 1'b0, 1, 0);
        instr(6'h2B, 6'h00, 1'b0, 0, 1);
        instr(6'h02, 6'h00, 1'b0, 0, 0);
        instr(6'h23, 6'h00, 1'b0, 2, 0);

        // abort mid-LW
        opc = 6'h23; func = '0;
        push(F, 1'b1); push(D, 1'b0); push(MA, 1'b0); push(MRD, 1'b0);
        run_q();
        do_reset();
        instr(6'h00, 6'h20, 1'b0, 0, 0);

        // SW with memReady stuck low -> fault, HALT ignores memReady
        opc = 6'h2B; func = '0;
        push(F, 1'b1); push(D, 1'b0); push(MA, 1'b0);
        for (int i = 0; i < TMO; i++) push(MWR, 1'b0);
        for (int i = 0; i < 4; i++) push(HLT, 1'b1);
        run_q();
        do_reset();
        instr(6'h02, 6'h00, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
